// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter
// Shares one DRAM request controller (address FIFO, write-data FIFO and
// read-data FIFO) among three masters: 0 = graphics command fetch,
// 1 = frame filler, 2 = line engine. Whole transactions are granted
// round-robin. A read is one address push. A write is one address push
// followed by two 128-bit data beats. Every read returns two data beats.
// A small tag FIFO records which master issued each outstanding read, so
// that the returned beats are steered back to that master.
module dram_req_arbiter #(
  parameter int MAX_RD = 4,
  parameter int ADDR_W = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  // master side
  input  logic [2:0]            req_valid,
  input  logic [2:0]            req_write,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [383:0]          req_wdata,
  input  logic [47:0]           req_wmask,
  output logic [2:0]            req_beat_ack,
  output logic [2:0]            req_done,
  output logic [2:0]            rd_valid,
  output logic [127:0]          rd_data,
  // address FIFO
  input  logic                  af_full,
  output logic                  af_wr_en,
  output logic [2:0]            af_cmd_din,
  output logic [ADDR_W-1:0]     af_addr_din,
  // write-data FIFO
  input  logic                  wdf_full,
  output logic                  wdf_wr_en,
  output logic [127:0]          wdf_din,
  output logic [15:0]           wdf_mask_din,
  // read-data FIFO
  input  logic                  rdf_valid,
  input  logic [127:0]          rdf_dout,
  output logic                  rdf_rd_en
);

  // Counter holds 0..MAX_RD inclusive; the tag FIFO holds exactly MAX_RD
  // entries, so the outstanding count doubles as its occupancy.
  localparam int CNT_W = $clog2(MAX_RD + 1);
  localparam int PTR_W = (MAX_RD > 1) ? $clog2(MAX_RD) : 1;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WD0  = 2'd2,
    WD1  = 2'd3
  } state_t;

  // Next master in the wrap-around search order 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    logic [1:0] nxt;
    case (idx)
      2'd0:    nxt = 2'd1;
      2'd1:    nxt = 2'd2;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

  // One-hot select for a master index; an invalid index selects nothing.
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Tag FIFO pointer advance, wrapping after the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] nxt;
    if (p == PTR_W'(MAX_RD - 1)) begin
      nxt = '0;
    end else begin
      nxt = p + PTR_W'(1);
    end
    return nxt;
  endfunction

  state_t             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         last_q, last_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [PTR_W-1:0]   tag_wr_ptr_q, tag_wr_ptr_d;
  logic [PTR_W-1:0]   tag_rd_ptr_q, tag_rd_ptr_d;
  logic               beat_q, beat_d;
  logic [1:0]         tag_mem_q [MAX_RD];
  logic [1:0]         tag_mem_d [MAX_RD];

  // Signals of the currently granted master.
  logic               g_write;
  logic [ADDR_W-1:0]  g_addr;
  logic [127:0]       g_wdata;
  logic [15:0]        g_wmask;
  logic [2:0]         grant_oh;

  // Round-robin search candidates in priority order.
  logic [1:0]         cand0, cand1, cand2;

  // Tag FIFO traffic for this cycle.
  logic               rd_push;
  logic               rd_pop;
  logic               tag_nonempty;
  logic [1:0]         tag_head;

  // Select the request fields of the granted master.
  always_comb begin
    g_write = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    g_wmask = '0;
    case (grant_q)
      2'd0: begin
        g_write = req_write[0];
        g_addr  = req_addr[0 +: ADDR_W];
        g_wdata = req_wdata[0 +: 128];
        g_wmask = req_wmask[0 +: 16];
      end
      2'd1: begin
        g_write = req_write[1];
        g_addr  = req_addr[ADDR_W +: ADDR_W];
        g_wdata = req_wdata[128 +: 128];
        g_wmask = req_wmask[16 +: 16];
      end
      default: begin
        g_write = req_write[2];
        g_addr  = req_addr[2*ADDR_W +: ADDR_W];
        g_wdata = req_wdata[256 +: 128];
        g_wmask = req_wmask[32 +: 16];
      end
    endcase
  end

  assign grant_oh     = onehot3(grant_q);
  assign af_addr_din  = g_addr;
  assign af_cmd_din   = g_write ? CMD_WRITE : CMD_READ;
  assign wdf_din      = g_wdata;
  assign wdf_mask_din = g_wmask;

  // Grant FSM: round-robin pick in IDLE, address push, then two write beats.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    af_wr_en     = 1'b0;
    wdf_wr_en    = 1'b0;
    req_beat_ack = 3'b000;
    req_done     = 3'b000;
    rd_push      = 1'b0;
    cand0        = rr_next(last_q);
    cand1        = rr_next(cand0);
    cand2        = last_q;
    case (state_q)
      IDLE: begin
        if (req_valid[cand0]) begin
          grant_d = cand0;
          last_d  = cand0;
          state_d = ADDR;
        end else if (req_valid[cand1]) begin
          grant_d = cand1;
          last_d  = cand1;
          state_d = ADDR;
        end else if (req_valid[cand2]) begin
          grant_d = cand2;
          last_d  = cand2;
          state_d = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        // Reads are held back once MAX_RD are in flight; writes never are.
        if (!af_full && (g_write || (outstanding_q < CNT_W'(MAX_RD)))) begin
          af_wr_en = 1'b1;
          if (g_write) begin
            state_d = WD0;
          end else begin
            req_done = grant_oh;
            rd_push  = 1'b1;
            state_d  = IDLE;
          end
        end else begin
          state_d = ADDR;
        end
      end
      WD0: begin
        if (!wdf_full) begin
          wdf_wr_en    = 1'b1;
          req_beat_ack = grant_oh;
          state_d      = WD1;
        end else begin
          state_d = WD0;
        end
      end
      WD1: begin
        if (!wdf_full) begin
          wdf_wr_en    = 1'b1;
          req_beat_ack = grant_oh;
          req_done     = grant_oh;
          state_d      = IDLE;
        end else begin
          state_d = WD1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read return: pop a beat whenever an owner is known, steer it by tag.
  always_comb begin
    tag_nonempty = (outstanding_q != '0);
    tag_head     = tag_mem_q[tag_rd_ptr_q];
    rdf_rd_en    = rdf_valid && tag_nonempty;
    rd_data      = rdf_dout;
    if (rdf_rd_en) begin
      rd_valid = onehot3(tag_head);
      beat_d   = ~beat_q;
    end else begin
      rd_valid = 3'b000;
      beat_d   = beat_q;
    end
    // The second beat of a read retires its tag.
    rd_pop = rdf_rd_en && beat_q;
  end

  // Tag FIFO bookkeeping and outstanding-read count.
  always_comb begin
    tag_mem_d = tag_mem_q;
    if (rd_push) begin
      tag_mem_d[tag_wr_ptr_q] = grant_q;
      tag_wr_ptr_d            = ptr_inc(tag_wr_ptr_q);
    end else begin
      tag_wr_ptr_d = tag_wr_ptr_q;
    end
    if (rd_pop) begin
      tag_rd_ptr_d = ptr_inc(tag_rd_ptr_q);
    end else begin
      tag_rd_ptr_d = tag_rd_ptr_q;
    end
    // A push and a retire in the same cycle cancel out.
    case ({rd_push, rd_pop})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Control state registers with synchronous reset; last = 2 so master 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= 2'd0;
      last_q        <= 2'd2;
      outstanding_q <= '0;
      tag_wr_ptr_q  <= '0;
      tag_rd_ptr_q  <= '0;
      beat_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      outstanding_q <= outstanding_d;
      tag_wr_ptr_q  <= tag_wr_ptr_d;
      tag_rd_ptr_q  <= tag_rd_ptr_d;
      beat_q        <= beat_d;
    end
  end

  // Tag storage; contents are only read while the occupancy count is non-zero.
  always_ff @(posedge clk) begin
    tag_mem_q <= tag_mem_d;
  end

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Directed bench for dram_req_arbiter: inputs are driven 2 time units after
// the rising edge and outputs are sampled on the falling edge.
module tb_dram_req_arbiter;

  localparam int ADDR_W = 31;
  localparam int MAX_RD = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [2:0]          req_valid;
  logic [2:0]          req_write;
  logic [3*ADDR_W-1:0] req_addr;
  logic [383:0]        req_wdata;
  logic [47:0]         req_wmask;
  logic [2:0]          req_beat_ack;
  logic [2:0]          req_done;
  logic [2:0]          rd_valid;
  logic [127:0]        rd_data;
  logic                af_full;
  logic                af_wr_en;
  logic [2:0]          af_cmd_din;
  logic [ADDR_W-1:0]   af_addr_din;
  logic                wdf_full;
  logic                wdf_wr_en;
  logic [127:0]        wdf_din;
  logic [15:0]         wdf_mask_din;
  logic                rdf_valid;
  logic [127:0]        rdf_dout;
  logic                rdf_rd_en;

  int vectors = 0;
  int errors  = 0;

  dram_req_arbiter #(.MAX_RD(MAX_RD), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .req_beat_ack(req_beat_ack), .req_done(req_done),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .af_full(af_full), .af_wr_en(af_wr_en), .af_cmd_din(af_cmd_din),
    .af_addr_din(af_addr_din),
    .wdf_full(wdf_full), .wdf_wr_en(wdf_wr_en), .wdf_din(wdf_din),
    .wdf_mask_din(wdf_mask_din),
    .rdf_valid(rdf_valid), .rdf_dout(rdf_dout), .rdf_rd_en(rdf_rd_en)
  );

  always #5 clk = ~clk;

  // Control outputs packed as {af_wr_en, wdf_wr_en, beat_ack, done, rd_valid}.
  function automatic logic [10:0] ctl_v();
    return {af_wr_en, wdf_wr_en, req_beat_ack, req_done, rd_valid};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_master(input int m, input logic [ADDR_W-1:0] a,
                            input logic [127:0] d, input logic [15:0] mk);
    req_addr[m*ADDR_W +: ADDR_W] = a;
    req_wdata[m*128 +: 128]      = d;
    req_wmask[m*16 +: 16]        = mk;
  endtask

  task automatic do_reset();
    cyc();
    rst       = 1'b1;
    req_valid = 3'b000;
    req_write = 3'b000;
    af_full   = 1'b0;
    wdf_full  = 1'b0;
    rdf_valid = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  // Called in the IDLE cycle that grants master m; runs ADDR, WD0 and WD1.
  task automatic wr_body(input int m, input logic [ADDR_W-1:0] a,
                         input logic [127:0] da, input logic [127:0] db,
                         input logic [15:0] ma, input logic [15:0] mb);
    logic [2:0] oh;
    oh = 3'b001 << m;
    cyc();
    set_master(m, a, da, ma);
    #3;
    chk("wr_addr_ctl", ctl_v(), {1'b1, 1'b0, 3'b000, 3'b000, 3'b000});
    chk("wr_addr", af_addr_din, a);
    chk("wr_cmd", af_cmd_din, 3'b000);
    cyc();
    #3;
    chk("wr_beat_a_ctl", ctl_v(), {1'b0, 1'b1, oh, 3'b000, 3'b000});
    chk("wr_beat_a_data", wdf_din, da);
    chk("wr_beat_a_mask", wdf_mask_din, ma);
    cyc();
    set_master(m, a, db, mb);
    #3;
    chk("wr_beat_b_ctl", ctl_v(), {1'b0, 1'b1, oh, oh, 3'b000});
    chk("wr_beat_b_data", wdf_din, db);
    chk("wr_beat_b_mask", wdf_mask_din, mb);
  endtask

  initial begin
    logic [2:0]   exp_rv [4];
    logic [127:0] ret_data [4];
    exp_rv   = '{3'b001, 3'b001, 3'b100, 3'b100};
    ret_data = '{128'hD0D0_0000_0000_0000_0000_0000_0000_00D0,
                 128'hD1D1_0000_0000_0000_0000_0000_0000_00D1,
                 128'hD2D2_0000_0000_0000_0000_0000_0000_00D2,
                 128'hD3D3_0000_0000_0000_0000_0000_0000_00D3};

    rst       = 1'b1;
    req_valid = 3'b000;
    req_write = 3'b000;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    af_full   = 1'b0;
    wdf_full  = 1'b0;
    rdf_valid = 1'b0;
    rdf_dout  = '0;

    // Reset state.
    cyc();
    cyc();
    #3;
    chk("rst_ctl", ctl_v(), 11'd0);
    chk("rst_rd_en", rdf_rd_en, 1'b0);

    // Master 1 write, one-cycle request-to-push latency.
    cyc();
    rst       = 1'b0;
    req_valid = 3'b010;
    req_write = 3'b010;
    #3;
    chk("t1_idle", ctl_v(), 11'd0);
    wr_body(1, 31'h0400000, 128'hAAAA_AAAA_0000_0000_0000_0000_0000_000A,
            128'hBBBB_BBBB_0000_0000_0000_0000_0000_000B, 16'h0000, 16'h00F0);
    cyc();
    req_valid = 3'b000;
    #3;
    chk("t1_after", ctl_v(), 11'd0);

    // Three simultaneous writers: order 0,1,2, then 0,2.
    do_reset();
    req_valid = 3'b111;
    req_write = 3'b111;
    #3;
    chk("t2_idle", ctl_v(), 11'd0);
    wr_body(0, 31'h0000100, 128'h10, 128'h11, 16'h0001, 16'h0002);
    cyc();
    req_valid = 3'b110;
    #3;
    chk("t2_gap0", ctl_v(), 11'd0);
    wr_body(1, 31'h0000200, 128'h20, 128'h21, 16'h0010, 16'h0020);
    cyc();
    req_valid = 3'b101;
    #3;
    chk("t2_gap1", ctl_v(), 11'd0);
    wr_body(2, 31'h0000300, 128'h30, 128'h31, 16'h0100, 16'h0200);
    cyc();
    req_valid = 3'b101;
    #3;
    chk("t2_gap2", ctl_v(), 11'd0);
    wr_body(0, 31'h0000400, 128'h40, 128'h41, 16'h1000, 16'h2000);
    cyc();
    req_valid = 3'b100;
    #3;
    chk("t2_gap3", ctl_v(), 11'd0);
    wr_body(2, 31'h0000500, 128'h50, 128'h51, 16'hFFFF, 16'h0000);
    cyc();
    req_valid = 3'b000;
    #3;
    chk("t2_after", ctl_v(), 11'd0);

    // Master 0 issues five reads; the fifth waits for a full return.
    do_reset();
    req_valid = 3'b001;
    req_write = 3'b000;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) cyc();
      set_master(0, 31'h0001000 + 31'(k), 128'h0, 16'h0);
      #3;
      chk("t3_idle", ctl_v(), 11'd0);
      cyc();
      #3;
      chk("t3_rd_ctl", ctl_v(), {1'b1, 1'b0, 3'b000, 3'b001, 3'b000});
      chk("t3_rd_addr", af_addr_din, 31'h0001000 + 31'(k));
      chk("t3_rd_cmd", af_cmd_din, 3'b001);
    end
    cyc();
    set_master(0, 31'h0001004, 128'h0, 16'h0);
    #3;
    chk("t3_idle5", ctl_v(), 11'd0);
    cyc();
    #3;
    chk("t3_stall0", ctl_v(), 11'd0);
    cyc();
    #3;
    chk("t3_stall1", ctl_v(), 11'd0);
    cyc();
    rdf_valid = 1'b1;
    rdf_dout  = 128'hCAFE_0000_0000_0000_0000_0000_0000_0001;
    #3;
    chk("t3_ret0_ctl", ctl_v(), {1'b0, 1'b0, 3'b000, 3'b000, 3'b001});
    chk("t3_ret0_data", rd_data, 128'hCAFE_0000_0000_0000_0000_0000_0000_0001);
    chk("t3_ret0_pop", rdf_rd_en, 1'b1);
    cyc();
    rdf_dout = 128'hCAFE_0000_0000_0000_0000_0000_0000_0002;
    #3;
    chk("t3_ret1_ctl", ctl_v(), {1'b0, 1'b0, 3'b000, 3'b000, 3'b001});
    chk("t3_ret1_data", rd_data, 128'hCAFE_0000_0000_0000_0000_0000_0000_0002);
    cyc();
    rdf_valid = 1'b0;
    #3;
    chk("t3_rd5_ctl", ctl_v(), {1'b1, 1'b0, 3'b000, 3'b001, 3'b000});
    chk("t3_rd5_addr", af_addr_din, 31'h0001004);
    cyc();
    req_valid = 3'b000;
    #3;
    chk("t3_after", ctl_v(), 11'd0);

    // Reads from masters 0 and 2; returns steered by tag.
    do_reset();
    req_valid = 3'b101;
    req_write = 3'b000;
    rdf_valid = 1'b1;
    rdf_dout  = 128'hDEAD;
    set_master(0, 31'h0002000, 128'h0, 16'h0);
    set_master(2, 31'h0002200, 128'h0, 16'h0);
    #3;
    chk("t4_empty_ctl", ctl_v(), 11'd0);
    chk("t4_empty_pop", rdf_rd_en, 1'b0);
    cyc();
    rdf_valid = 1'b0;
    #3;
    chk("t4_rd0_ctl", ctl_v(), {1'b1, 1'b0, 3'b000, 3'b001, 3'b000});
    chk("t4_rd0_addr", af_addr_din, 31'h0002000);
    cyc();
    req_valid = 3'b100;
    #3;
    chk("t4_gap", ctl_v(), 11'd0);
    cyc();
    #3;
    chk("t4_rd2_ctl", ctl_v(), {1'b1, 1'b0, 3'b000, 3'b100, 3'b000});
    chk("t4_rd2_addr", af_addr_din, 31'h0002200);
    cyc();
    req_valid = 3'b000;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) cyc();
      rdf_valid = 1'b1;
      rdf_dout  = ret_data[k];
      #3;
      chk("t4_ret_ctl", ctl_v(), {1'b0, 1'b0, 3'b000, 3'b000, exp_rv[k]});
      chk("t4_ret_data", rd_data, ret_data[k]);
    end
    cyc();
    #3;
    chk("t4_drained_pop", rdf_rd_en, 1'b0);
    chk("t4_drained_ctl", ctl_v(), 11'd0);

    // Write from master 0 with address and write-data FIFO back-pressure.
    cyc();
    rdf_valid = 1'b0;
    req_valid = 3'b001;
    req_write = 3'b001;
    #3;
    chk("t5_idle", ctl_v(), 11'd0);
    cyc();
    af_full = 1'b1;
    set_master(0, 31'h0003000, 128'h5A5A_0001, 16'h000F);
    #3;
    chk("t5_af_stall", ctl_v(), 11'd0);
    cyc();
    af_full = 1'b0;
    #3;
    chk("t5_addr_ctl", ctl_v(), {1'b1, 1'b0, 3'b000, 3'b000, 3'b000});
    chk("t5_addr", af_addr_din, 31'h0003000);
    for (int k = 0; k < 3; k++) begin
      cyc();
      wdf_full = 1'b1;
      #3;
      chk("t5_wdf_stall", ctl_v(), 11'd0);
    end
    cyc();
    wdf_full = 1'b0;
    #3;
    chk("t5_beat_a_ctl", ctl_v(), {1'b0, 1'b1, 3'b001, 3'b000, 3'b000});
    chk("t5_beat_a_data", wdf_din, 128'h5A5A_0001);
    cyc();
    set_master(0, 31'h0003000, 128'h5A5A_0002, 16'h00F0);
    #3;
    chk("t5_beat_b_ctl", ctl_v(), {1'b0, 1'b1, 3'b001, 3'b001, 3'b000});
    chk("t5_beat_b_mask", wdf_mask_din, 16'h00F0);
    cyc();
    req_valid = 3'b000;
    #3;
    chk("t5_after", ctl_v(), 11'd0);

    // One read from master 2 in flight, then reset during a write's WD1.
    cyc();
    req_valid = 3'b100;
    req_write = 3'b000;
    set_master(2, 31'h0004000, 128'h0, 16'h0);
    #3;
    chk("t6_idle", ctl_v(), 11'd0);
    cyc();
    #3;
    chk("t6_rd_ctl", ctl_v(), {1'b1, 1'b0, 3'b000, 3'b100, 3'b000});
    cyc();
    req_valid = 3'b010;
    req_write = 3'b010;
    set_master(1, 31'h0005000, 128'h6161, 16'h0);
    #3;
    chk("t6_gap", ctl_v(), 11'd0);
    cyc();
    #3;
    chk("t6_wr_addr_ctl", ctl_v(), {1'b1, 1'b0, 3'b000, 3'b000, 3'b000});
    chk("t6_wr_addr", af_addr_din, 31'h0005000);
    cyc();
    #3;
    chk("t6_wd0_ctl", ctl_v(), {1'b0, 1'b1, 3'b010, 3'b000, 3'b000});
    cyc();
    rst      = 1'b1;
    wdf_full = 1'b1;
    #3;
    chk("t6_wd1_hold", ctl_v(), 11'd0);
    cyc();
    rst       = 1'b0;
    wdf_full  = 1'b0;
    rdf_valid = 1'b1;
    req_valid = 3'b111;
    req_write = 3'b111;
    set_master(0, 31'h0006000, 128'h0, 16'h0);
    set_master(2, 31'h0006200, 128'h0, 16'h0);
    #3;
    chk("t6_post_rst_ctl", ctl_v(), 11'd0);
    chk("t6_post_rst_pop", rdf_rd_en, 1'b0);
    cyc();
    rdf_valid = 1'b0;
    #3;
    chk("t6_first_grant_ctl", ctl_v(), {1'b1, 1'b0, 3'b000, 3'b000, 3'b000});
    chk("t6_first_grant_addr", af_addr_din, 31'h0006000);

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
